// File: rtl/ma_stage_ctrl_if.sv
// ma_stage_ctrl_if
// Data-memory request/acknowledge bundle between the memory-access stage
// controller (master) and the data memory (slave).
//   dmem_req   : access request, held until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : byte address
//   dmem_wdata : store data
//   dmem_ack   : one-cycle completion pulse from memory
//   dmem_rdata : load data, valid while dmem_ack = 1
interface ma_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/ma_stage_ctrl.sv
// ma_stage_ctrl
// Memory-access stage controller. Drives the data-memory handshake from the
// EX/MA register, stalls the pipeline until the memory acknowledges, resolves
// branch/jump redirects and registers the MA/WB pipeline outputs.
//
// Optional build macro: MA_TIMEOUT_EN enables a watchdog that aborts a BUSY
// access after TIMEOUT_CYCLES cycles and sets the sticky bus_err_o flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_jM, pc_iM, zfM        jump target, branch target, ALU zero flag
//   ALUOutM, RtM, inst_m     address / ALU result, store data, instruction
//   WB_M [reg_write, mem_to_reg, link], MA_M [mem_read, mem_write, branch, jump]
//   dmem                     data-memory handshake (master side)
//   stall_o, pcsrc_o, pc_target_o, flush_o   pipeline control to fetch/hazard
//   ReadDataW, ALUOutW, inst_w, WB_W          MA/WB register
//   bus_err_o                sticky access-timeout flag
//
// state | meaning
// IDLE  | no access outstanding; request driven straight from EX/MA
// BUSY  | access outstanding; latched address/data driven until ack
module ma_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_jM,
    input  logic [31:0]           pc_iM,
    input  logic                  zfM,
    input  logic [31:0]           ALUOutM,
    input  logic [31:0]           RtM,
    input  logic [31:0]           inst_m,
    input  logic [2:0]            WB_M,
    input  logic [3:0]            MA_M,
    ma_stage_ctrl_if.master       dmem,
    output logic                  stall_o,
    output logic                  pcsrc_o,
    output logic [31:0]           pc_target_o,
    output logic                  flush_o,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           ALUOutW,
    output logic [31:0]           inst_w,
    output logic [2:0]            WB_W,
    output logic                  bus_err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        memop;
    logic        is_load;
    logic        timeout;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    assign memop   = MA_M[0] | MA_M[1];
    // A combined read+write is a write, so only a pure read returns data.
    assign is_load = MA_M[0] & ~MA_M[1];

    // A watchdog abort completes the instruction exactly like an ack.
    assign stall_o     = memop & ~dmem.dmem_ack & ~timeout;
    assign pcsrc_o     = (MA_M[2] & zfM) | MA_M[3];
    assign pc_target_o = MA_M[3] ? pc_jM : pc_iM;
    // EX/MA is held while stalled, so the redirect waits for completion.
    assign flush_o     = pcsrc_o & ~stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = 32'h0;
        dmem.dmem_wdata = 32'h0;
        case (state)
            IDLE: begin
                dmem.dmem_req   = memop;
                dmem.dmem_we    = MA_M[1];
                dmem.dmem_addr  = ALUOutM;
                dmem.dmem_wdata = RtM;
                if (memop && !dmem.dmem_ack) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = we_q;
                dmem.dmem_addr  = addr_q;
                dmem.dmem_wdata = wdata_q;
                if (dmem.dmem_ack || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request on entry to BUSY so it stays stable until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
        end else if (state == IDLE && state_nxt == BUSY) begin
            addr_q  <= ALUOutM;
            wdata_q <= RtM;
            we_q    <= MA_M[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ReadDataW <= 32'h0;
            ALUOutW   <= 32'h0;
            inst_w    <= 32'h0;
            WB_W      <= 3'b000;
        end else if (!stall_o) begin
            if (is_load) begin
                ReadDataW <= timeout ? 32'h0 : dmem.dmem_rdata;
            end
            ALUOutW <= ALUOutM;
            inst_w  <= inst_m;
            WB_W    <= WB_M;
        end else begin
            inst_w <= 32'h0;
            WB_W   <= 3'b000;
        end
    end

`ifdef MA_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;
    logic          bus_err_q;

    assign timeout   = (state == BUSY) && !dmem.dmem_ack &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == BUSY && state_nxt == BUSY) begin
                to_cnt <= to_cnt + CW'(1);
            end else begin
                to_cnt <= '0;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    // Watchdog absent: never fires. The parameter is referenced so both
    // builds share one parameter list without an unused-parameter warning.
    assign timeout   = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign bus_err_o = 1'b0;
`endif

endmodule
